arc_main_memory: RTL and testbench

Word-organised main-memory responder for the ARC datapath. The datapath acts as initiator: bus A carries the byte address, bus B the store data, and `rdata` returns on the datapath's memory input into bus C. Each `rd` or `wr` request is served through a small FSM with programmable wait states. A one-cycle `ack` tells the control unit when to latch `rdata` or continue after a store.

---
 rtl/arc_main_memory.sv | 142 ++++++++++++++
 tb/tb_arc_main_memory.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/arc_main_memory.sv
// arc_main_memory: word-organised main-memory responder for the ARC datapath.
// Serves one rd or wr request at a time through IDLE -> WAIT -> ACCESS -> RESP.
// The number of wait states is set by WAIT.
// Optional build macro ARC_MM_ALIGN_CHECK_EN: when defined, a byte address with
// addr[1:0] != 00 is rejected with err instead of accessing the containing word.
module arc_main_memory #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int WAIT  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic        err_o
);

`ifdef ARC_MM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] wordIdx;
  logic          accessBad;
  logic          memWe;
  logic          memRe;

  assign wordIdx   = addr_q[AW+1:2];
  assign accessBad = (|addr_q[31:AW+2]) | (ALIGN_CHECK & (|addr_q[1:0]));

  // Next-state logic: latch the request in IDLE, count wait states, then access and respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    memWe   = 1'b0;
    memRe   = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (rd_i && wr_i) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (rd_i ^ wr_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          write_d = wr_i;
          cnt_d   = 4'(WAIT);
          state_d = (WAIT == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (accessBad) begin
          err_d = 1'b1;
        end else if (write_q) begin
          memWe = 1'b1;
        end else begin
          memRe = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Read data register: only a successful read replaces it; reset clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
    end else if (memRe) begin
      rdata_q <= mem_q[wordIdx];
    end
  end

  // Storage array: not reset, and a reset on the commit edge cancels the store
  always_ff @(posedge clk_i) begin
    if (memWe && !rst_i) begin
      mem_q[wordIdx] <= wdata_q;
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = (state_q == S_RESP);
  assign busy_o  = (state_q != S_IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_arc_main_memory.sv
// tb_arc_main_memory: directed self-checking bench for arc_main_memory.
// Three instances share clock and reset: unit 0 has WAIT=2, unit 1 has WAIT=0,
// and unit 2 has WAIT=3. Latency is the number of rising edges from the request
// edge (counted as 1) up to and including the edge after which ack is seen,
// which is WAIT+2.
module tb_arc_main_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        busy  [3];
  logic        err   [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  arc_main_memory #(.DEPTH(1024), .AW(10), .WAIT(2)) u0 (
    .clk_i(clk), .rst_i(rst), .rd_i(rd[0]), .wr_i(wr[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .busy_o(busy[0]), .err_o(err[0])
  );

  arc_main_memory #(.DEPTH(1024), .AW(10), .WAIT(0)) u1 (
    .clk_i(clk), .rst_i(rst), .rd_i(rd[1]), .wr_i(wr[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .busy_o(busy[1]), .err_o(err[1])
  );

  arc_main_memory #(.DEPTH(1024), .AW(10), .WAIT(3)) u2 (
    .clk_i(clk), .rst_i(rst), .rd_i(rd[2]), .wr_i(wr[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ack_o(ack[2]), .busy_o(busy[2]), .err_o(err[2])
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on unit u and wait (bounded) for ack; lat=-1 on timeout
  task automatic applyStimulus(input int u, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               output int lat, output int busyCnt);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy[u] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rd[u]    = r;
    wr[u]    = w;
    addr[u]  = a;
    wdata[u] = d;
    lat      = -1;
    busyCnt  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        addr[u]  = ~a;
        wdata[u] = ~d;
      end
      if (busy[u]) busyCnt++;
      if (ack[u]) begin
        lat   = i;
        rd[u] = 1'b0;
        wr[u] = 1'b0;
        break;
      end
    end
    if (lat < 0) begin
      rd[u] = 1'b0;
      wr[u] = 1'b0;
    end
  endtask

  // Request plus latency and err checks, still inside the ack cycle on return
  task automatic request(input string tag, input int u, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input int expLat, input logic expErr, output int busyCnt);
    int lat;
    applyStimulus(u, r, w, a, d, lat, busyCnt);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_err"}, {31'd0, err[u]}, {31'd0, expErr});
  endtask

  initial begin
    int bc;
    int ackSeen;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rdata", rdata[0], 32'd0);
    checkOutput("rst_ack",   {31'd0, ack[0]},  32'd0);
    checkOutput("rst_busy",  {31'd0, busy[0]}, 32'd0);
    checkOutput("rst_err",   {31'd0, err[0]},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // WAIT=2 write then read, in range
    request("wr10", 0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4, 1'b0, bc);
    checkOutput("wr10_busy", 32'(bc), 32'd4);
    @(posedge clk);
    #1;
    checkOutput("ack_pulse", {31'd0, ack[0]}, 32'd0);
    request("rd10", 0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4, 1'b0, bc);
    checkOutput("rd10_data", rdata[0], 32'hDEAD_BEEF);

    // Out-of-range accesses must not alias onto word 0
    request("wr0", 0, 1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4, 1'b0, bc);
    request("wr1000", 0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_1234, 4, 1'b1, bc);
    request("rd1000", 0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4, 1'b1, bc);
    checkOutput("rd1000_keep", rdata[0], 32'hDEAD_BEEF);
    request("wrhigh", 0, 1'b0, 1'b1, 32'h8000_0000, 32'h7777_7777, 4, 1'b1, bc);
    request("rd0", 0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4, 1'b0, bc);
    checkOutput("rd0_data", rdata[0], 32'h0BAD_F00D);

    // Illegal request: straight to RESP, no access
    request("illegal", 0, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 1, 1'b1, bc);
    checkOutput("illegal_keep", rdata[0], 32'h0BAD_F00D);
    request("rd10b", 0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4, 1'b0, bc);
    checkOutput("rd10b_data", rdata[0], 32'hDEAD_BEEF);

    // Misaligned read of byte 0x12 (word 0x10)
    request("rd0b", 0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4, 1'b0, bc);
`ifdef ARC_MM_ALIGN_CHECK_EN
    request("rd12", 0, 1'b1, 1'b0, 32'h0000_0012, 32'h0, 4, 1'b1, bc);
    checkOutput("rd12_data", rdata[0], 32'h0BAD_F00D);
`else
    request("rd12", 0, 1'b1, 1'b0, 32'h0000_0012, 32'h0, 4, 1'b0, bc);
    checkOutput("rd12_data", rdata[0], 32'hDEAD_BEEF);
`endif

    // WAIT=0: ack two edges in, busy for two cycles
    request("w0_wr", 1, 1'b0, 1'b1, 32'h0000_0010, 32'h1357_9BDF, 2, 1'b0, bc);
    request("w0_rd", 1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, bc);
    checkOutput("w0_busy", 32'(bc), 32'd2);
    checkOutput("w0_data", rdata[1], 32'h1357_9BDF);

    // WAIT=3: establish old contents, then reset in the middle of a write
    request("w3_wr", 2, 1'b0, 1'b1, 32'h0000_0020, 32'h55AA_33CC, 5, 1'b0, bc);
    request("w3_rd", 2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5, 1'b0, bc);
    checkOutput("w3_data", rdata[2], 32'h55AA_33CC);
    @(negedge clk);
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 32'h0000_0020; wdata[2] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    checkOutput("mid_busy", {31'd0, busy[2]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr[2] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rdata", rdata[2], 32'd0);
    checkOutput("mid_ack",  {31'd0, ack[2]},  32'd0);
    checkOutput("mid_busy0", {31'd0, busy[2]}, 32'd0);
    checkOutput("mid_err",  {31'd0, err[2]},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ackSeen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ack[2]) ackSeen++;
    end
    checkOutput("mid_noack", 32'(ackSeen), 32'd0);
    request("w3_rd2", 2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5, 1'b0, bc);
    checkOutput("w3_old", rdata[2], 32'h55AA_33CC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
